// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: register-address width, write-address select
// encoding and the default link register used by the write-address selector.
package cpu_pkg;

    localparam int REG_AD_W         = 3;
    localparam int LINK_REG_DEFAULT = (1 << REG_AD_W) - 1;

    typedef enum logic [1:0] {
        WR_SEL_RT   = 2'd0,
        WR_SEL_RD   = 2'd1,
        WR_SEL_LINK = 2'd2,
        WR_SEL_RSVD = 2'd3
    } wr_sel_t;

    function automatic logic is_rsvd_sel(input wr_sel_t sel);
        return (sel == WR_SEL_RSVD);
    endfunction

endpackage

// File: rtl/mux_2_pipe_reg.sv
// Plain synchronous-reset pipeline flop for the selected write address plus its
// write enable; no stall, cleared to zero while rst is high.
module mux_2_pipe_reg #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/mux_2.sv
// Register-file write-address selector: rt / rd / link register under M2, with a
// one-cycle registered copy of address and write enable.
// Optional macro MUX_2_ZERO_GUARD_EN suppresses registered writes to address 0.
module mux_2
    import cpu_pkg::*;
#(
    parameter int N        = REG_AD_W,
    parameter int LINK_REG = (1 << N) - 1
) (
    input  logic         clk,
    input  logic         rst,
    input  wr_sel_t      M2,
    input  logic [N-1:0] rt,
    input  logic [N-1:0] rd,
    input  logic         reg_wr_en,
    output logic [N-1:0] Reg_write_ad,
    output logic         sel_err,
    output logic [N-1:0] Reg_write_ad_q,
    output logic         reg_wr_en_q
);

    localparam logic [N-1:0] LINK_AD = N'(LINK_REG);

    logic         w_wr_en_next;
    logic [N:0]   w_pipe_d;
    logic [N:0]   w_pipe_q;

    // Unknown selects fall into the default branch and yield address 0.
    always_comb begin
        Reg_write_ad = '0;
        sel_err      = 1'b0;
        case (M2)
            WR_SEL_RT:   Reg_write_ad = rt;
            WR_SEL_RD:   Reg_write_ad = rd;
            WR_SEL_LINK: Reg_write_ad = LINK_AD;
            WR_SEL_RSVD: sel_err      = 1'b1;
            default:     Reg_write_ad = '0;
        endcase
    end

`ifdef MUX_2_ZERO_GUARD_EN
    // Register 0 is hard-wired, so a write aimed at it is dropped.
    assign w_wr_en_next = reg_wr_en & ~sel_err & (|Reg_write_ad);
`else
    assign w_wr_en_next = reg_wr_en & ~sel_err;
`endif

    assign w_pipe_d = {w_wr_en_next, Reg_write_ad};

    mux_2_pipe_reg #(
        .W (N + 1)
    ) u_pipe_reg (
        .clk (clk),
        .rst (rst),
        .i_d (w_pipe_d),
        .o_q (w_pipe_q)
    );

    assign Reg_write_ad_q = w_pipe_q[N-1:0];
    assign reg_wr_en_q    = w_pipe_q[N];

endmodule

// File: tb/tb_mux_2.sv
// Self-checking bench for mux_2: directed scenarios plus randomized traffic
// checked against a rule-level reference model.
module tb_mux_2;
    import cpu_pkg::*;

    localparam int N = 3;
    localparam int LINK = 7;

    logic          clk = 1'b0;
    logic          rst;
    wr_sel_t       M2;
    logic [N-1:0]  rt;
    logic [N-1:0]  rd;
    logic          reg_wr_en;
    logic [N-1:0]  Reg_write_ad;
    logic          sel_err;
    logic [N-1:0]  Reg_write_ad_q;
    logic          reg_wr_en_q;

    int errors = 0;
    int checks = 0;

`ifdef MUX_2_ZERO_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    mux_2 #(.N(N), .LINK_REG(LINK)) dut (
        .clk            (clk),
        .rst            (rst),
        .M2             (M2),
        .rt             (rt),
        .rd             (rd),
        .reg_wr_en      (reg_wr_en),
        .Reg_write_ad   (Reg_write_ad),
        .sel_err        (sel_err),
        .Reg_write_ad_q (Reg_write_ad_q),
        .reg_wr_en_q    (reg_wr_en_q)
    );

    always #5 clk = ~clk;

    // Reference model written from the selection rules.
    function automatic int model_ad(input int sel, input int rt_v, input int rd_v);
        if (sel == 0) return rt_v % 8;
        if (sel == 1) return rd_v % 8;
        if (sel == 2) return LINK;
        return 0;
    endfunction

    function automatic int model_en(input int sel, input int ad, input int en, input int rst_v);
        if (rst_v != 0) return 0;
        if (en == 0 || sel == 3) return 0;
        if (GUARD && ad == 0) return 0;
        return 1;
    endfunction

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; M2 = WR_SEL_RD; rd = 3'd5; rt = 3'd0; reg_wr_en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            edge_step();
            checks++;
            if (Reg_write_ad_q !== 3'd0) begin
                errors++;
                $display("FAIL reset_ad_q edge%0d got=%0d exp=0", k, Reg_write_ad_q);
            end
            checks++;
            if (reg_wr_en_q !== 1'b0) begin
                errors++;
                $display("FAIL reset_en_q edge%0d got=%0b exp=0", k, reg_wr_en_q);
            end
            checks++;
            if (Reg_write_ad !== 3'd5) begin
                errors++;
                $display("FAIL reset_comb edge%0d got=%0d exp=5", k, Reg_write_ad);
            end
        end
        rst = 1'b0;
        edge_step();
        checks++;
        if (Reg_write_ad_q !== 3'd5) begin
            errors++;
            $display("FAIL release_ad_q got=%0d exp=5", Reg_write_ad_q);
        end
        checks++;
        if (reg_wr_en_q !== 1'b1) begin
            errors++;
            $display("FAIL release_en_q got=%0b exp=1", reg_wr_en_q);
        end
        $display("test_reset done");
    endtask

    task automatic test_comb();
        int rt_w = 20;
        int rd_w = 30;
        rt = N'(rt_w); rd = N'(rd_w); M2 = WR_SEL_RT;
        #1;
        checks++;
        if (Reg_write_ad !== 3'd4 || sel_err !== 1'b0) begin
            errors++;
            $display("FAIL comb_rt got=%0d/%0b exp=4/0", Reg_write_ad, sel_err);
        end
        #4; M2 = WR_SEL_RD; #1;
        checks++;
        if (Reg_write_ad !== 3'd6 || sel_err !== 1'b0) begin
            errors++;
            $display("FAIL comb_rd got=%0d/%0b exp=6/0", Reg_write_ad, sel_err);
        end
        #4; M2 = WR_SEL_LINK; #1;
        checks++;
        if (Reg_write_ad !== 3'd7 || sel_err !== 1'b0) begin
            errors++;
            $display("FAIL comb_link got=%0d/%0b exp=7/0", Reg_write_ad, sel_err);
        end
        $display("test_comb done");
    endtask

    task automatic test_reserved();
        M2 = WR_SEL_RSVD; rt = 3'd5; rd = 3'd2; reg_wr_en = 1'b1;
        #1;
        checks++;
        if (Reg_write_ad !== 3'd0 || sel_err !== 1'b1) begin
            errors++;
            $display("FAIL rsvd_comb got=%0d/%0b exp=0/1", Reg_write_ad, sel_err);
        end
        edge_step();
        checks++;
        if (reg_wr_en_q !== 1'b0 || Reg_write_ad_q !== 3'd0) begin
            errors++;
            $display("FAIL rsvd_q got=%0d/%0b exp=0/0", Reg_write_ad_q, reg_wr_en_q);
        end
        $display("test_reserved done");
    endtask

    task automatic test_back_to_back();
        int exp_seq[3] = '{3, 6, 7};
        rt = 3'd3; rd = 3'd6; reg_wr_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            M2 = wr_sel_t'(k);
            edge_step();
            checks++;
            if (Reg_write_ad_q !== N'(exp_seq[k]) || reg_wr_en_q !== 1'b1) begin
                errors++;
                $display("FAIL b2b_%0d got=%0d/%0b exp=%0d/1", k, Reg_write_ad_q, reg_wr_en_q, exp_seq[k]);
            end
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_zero_guard();
        M2 = WR_SEL_RT; rt = 3'd0; reg_wr_en = 1'b1;
        edge_step();
        checks++;
        if (Reg_write_ad_q !== 3'd0 || reg_wr_en_q !== (GUARD ? 1'b0 : 1'b1)) begin
            errors++;
            $display("FAIL zero_guard got=%0d/%0b exp=0/%0b", Reg_write_ad_q, reg_wr_en_q, !GUARD);
        end
        $display("test_zero_guard done guard=%0b", GUARD);
    endtask

    task automatic test_random();
        int sel, rt_v, rd_v, en_v, rst_v, exp_ad, exp_q_ad, exp_q_en;
        for (int t = 0; t < 200; t++) begin
            sel   = int'($urandom_range(0, 3));
            rt_v  = int'($urandom_range(0, 7));
            rd_v  = int'($urandom_range(0, 7));
            en_v  = int'($urandom_range(0, 1));
            rst_v = ($urandom_range(0, 15) == 0) ? 1 : 0;
            M2 = wr_sel_t'(sel); rt = N'(rt_v); rd = N'(rd_v);
            reg_wr_en = en_v[0]; rst = rst_v[0];
            exp_ad = model_ad(sel, rt_v, rd_v);
            #1;
            checks++;
            if (Reg_write_ad !== N'(exp_ad) || sel_err !== (sel == 3)) begin
                errors++;
                $display("FAIL rand_comb t=%0d got=%0d/%0b exp=%0d/%0b", t, Reg_write_ad, sel_err, exp_ad, sel == 3);
            end
            exp_q_ad = (rst_v != 0) ? 0 : exp_ad;
            exp_q_en = model_en(sel, exp_ad, en_v, rst_v);
            edge_step();
            checks++;
            if (Reg_write_ad_q !== N'(exp_q_ad) || reg_wr_en_q !== exp_q_en[0]) begin
                errors++;
                $display("FAIL rand_q t=%0d got=%0d/%0b exp=%0d/%0d", t, Reg_write_ad_q, reg_wr_en_q, exp_q_ad, exp_q_en);
            end
            $display("txn %0d: rst=%0d M2=%0d rt=%0d rd=%0d en=%0d -> ad=%0d q=%0d/%0b",
                     t, rst_v, sel, rt_v, rd_v, en_v, Reg_write_ad, Reg_write_ad_q, reg_wr_en_q);
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; M2 = WR_SEL_RT; rt = '0; rd = '0; reg_wr_en = 1'b0;
        test_comb();
        edge_step();
        test_reset();
        test_reserved();
        test_back_to_back();
        test_zero_guard();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_2.md
Name: mux_2

Overview:
- Register-file write-address selector for the RISC CPU datapath.
- Chooses the destination register address from the instruction rt field, the rd field, or a fixed link register, under the 2-bit control M2 from the control unit.
- Provides a combinational address for same-cycle use and a registered copy (address plus write enable) for the write-back stage.

Parameters:
- N, 3, register-address width in bits (register file has 2^N entries).
- LINK_REG, 2^N-1 (7 at default N), address selected when M2=2; must fit in N bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- M2  input  2  write-address select: 0=rt, 1=rd, 2=LINK_REG, 3=reserved.
- rt  input  N  instruction rt field.
- rd  input  N  instruction rd field.
- reg_wr_en  input  1  register-write request from control.
- Reg_write_ad  output  N  combinational selected write address.
- sel_err  output  1  combinational; high when M2=3.
- Reg_write_ad_q  output  N  Reg_write_ad registered one cycle.
- reg_wr_en_q  output  1  registered write enable.

Behaviour:
- Reg_write_ad is purely combinational; it updates in the same delta as M2, rt or rd, with no clock dependency:
  - M2=0 gives rt.
  - M2=1 gives rd.
  - M2=2 gives LINK_REG.
  - M2=3 gives all-zeros, and sel_err=1.
- sel_err is 0 for M2 = 0, 1 or 2.
- Inputs are exactly N bits. Wider values driven by a bench are truncated by port width; there is no internal widening.
- X or Z on M2 drives Reg_write_ad to all-zeros (default branch). No latch is inferred.
- On each rising clk when rst=0:
  - Reg_write_ad_q <= Reg_write_ad.
  - reg_wr_en_q <= reg_wr_en & ~sel_err. A reserved select never produces a write.
- Latency: 0 cycles for Reg_write_ad and sel_err; 1 cycle for the _q outputs.
- Reset: while rst=1 at a rising edge, Reg_write_ad_q=0 and reg_wr_en_q=0.
  - Reset applies even if reg_wr_en=1 in the same cycle; reset wins.
  - Combinational outputs are unaffected by rst.
- Reset deasserted mid-stream: the first capture happens at the first rising edge with rst=0.
- No handshake and no state machine; the register stage is a plain pipeline flop with no stall input.

Optional Feature:
- Macro: MUX_2_ZERO_GUARD_EN.
- Defined: register 0 is hard-wired. reg_wr_en_q <= reg_wr_en & ~sel_err & (Reg_write_ad != 0), so writes targeting address 0 are suppressed. Reg_write_ad_q still captures 0.
- Undefined: no address-0 filtering; behaviour exactly as in Behaviour.

Decomposition:
- Shared package cpu_pkg holds:
  - localparam REG_AD_W = 3.
  - A 2-bit typedef wr_sel_t with constants WR_SEL_RT=0, WR_SEL_RD=1, WR_SEL_LINK=2, WR_SEL_RSVD=3.
  - LINK_REG default.
- M2 is declared as wr_sel_t.
- One natural sub-module, mux_2_pipe_reg: the N+1-bit synchronous-reset register holding address plus enable.
- Selection logic stays in mux_2.

Test Plan:
- N=3, M2=0, rt=20, rd=30 (truncated to rt=4, rd=6) -> Reg_write_ad=4, sel_err=0 immediately, no clock needed.
- At t=5 set M2=1 -> Reg_write_ad=6. At t=10 set M2=2 -> Reg_write_ad=7 (LINK_REG).
- M2=3, reg_wr_en=1, clock once -> Reg_write_ad=0, sel_err=1, reg_wr_en_q=0 after the edge.
- rst=1 with M2=1, rd=5, reg_wr_en=1 for 2 edges -> Reg_write_ad_q=0, reg_wr_en_q=0. Release rst, 1 edge -> Reg_write_ad_q=5, reg_wr_en_q=1.
- Back-to-back M2 sequence 0,1,2 with rt=3, rd=6, reg_wr_en=1 -> Reg_write_ad_q follows 3,6,7 lagging by one cycle.
- With MUX_2_ZERO_GUARD_EN: M2=0, rt=0, reg_wr_en=1 -> reg_wr_en_q=0 and Reg_write_ad_q=0. Without the macro -> reg_wr_en_q=1.
